// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART FIFO controller: FSM state enums,
// default FIFO depths and a pointer-width helper used by the byte FIFOs.
package uart_pkg;

    localparam int DEFAULT_TX_DEPTH = 4;
    localparam int DEFAULT_RX_DEPTH = 4;
    localparam int DATA_W           = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_BUSY,
        TX_RELEASE
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_WAIT,
        RX_ACK
    } rx_state_e;

    // A depth of 1 still needs a one-bit pointer so the index vector is legal.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO: head_o presents the oldest entry (0 when empty).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic [DATA_W-1:0]       push_data_i,
    input  logic                    pop_i,
    output logic [DATA_W-1:0]       head_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap explicitly at DEPTH-1 so the FIFO is correct for any depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// CPU-side FIFO controller for a UART: a TX FIFO drained by the TX handshake FSM
// and an RX FIFO filled by the RX handshake FSM, running independently.
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int TX_DEPTH = DEFAULT_TX_DEPTH,
    parameter int RX_DEPTH = DEFAULT_RX_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        tx_full,
    output logic [$clog2(TX_DEPTH):0]   tx_count,
    input  logic                        rd_en,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rx_empty,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic                        rx_overflow,
    input  logic                        ovf_clear,
    output logic                        start_tx,
    output logic [DATA_W-1:0]           tx_value,
    input  logic                        tx_done,
    input  logic                        rx_available,
    input  logic [DATA_W-1:0]           rx_value,
    output logic                        rx_clear
);

    tx_state_e         tx_state_q, tx_state_d;
    logic              start_tx_q, start_tx_d;
    logic [DATA_W-1:0] tx_value_q, tx_value_d;
    logic              tx_pop;
    logic              tx_empty;
    logic [DATA_W-1:0] tx_head;

    rx_state_e         rx_state_q, rx_state_d;
    logic              rx_clear_q, rx_clear_d;
    logic              rx_overflow_q, rx_overflow_d;
    logic              rx_push;
    logic              rx_full;

    // Writes into a full TX FIFO are dropped even if the FSM pops that cycle.
    byte_fifo #(
        .DEPTH       (TX_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (wr_en && !tx_full),
        .push_data_i (wr_data),
        .pop_i       (tx_pop),
        .head_o      (tx_head),
        .empty_o     (tx_empty),
        .full_o      (tx_full),
        .count_o     (tx_count)
    );

    byte_fifo #(
        .DEPTH       (RX_DEPTH)
    ) u_rx_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rx_push),
        .push_data_i (rx_value),
        .pop_i       (rd_en),
        .head_o      (rd_data),
        .empty_o     (rx_empty),
        .full_o      (rx_full),
        .count_o     (rx_count)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        start_tx_d = start_tx_q;
        tx_value_d = tx_value_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    start_tx_d = 1'b1;
                    tx_value_d = tx_head;
                    tx_state_d = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_done) begin
                    start_tx_d = 1'b0;
                    tx_state_d = TX_RELEASE;
                end
            end
            TX_RELEASE: begin
                start_tx_d = 1'b0;
                tx_state_d = TX_IDLE;
            end
            default: begin
                start_tx_d = 1'b0;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            start_tx_q <= 1'b0;
            tx_value_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            start_tx_q <= start_tx_d;
            tx_value_q <= tx_value_d;
        end
    end

    // rx_value is only trusted one cycle after rx_available rises, hence RX_WAIT.
    // A byte is lost only when the FIFO is full and the CPU is not popping.
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_clear_d    = rx_clear_q;
        rx_overflow_d = rx_overflow_q;
        rx_push       = 1'b0;
        if (ovf_clear) begin
            rx_overflow_d = 1'b0;
        end
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_available) begin
                    rx_state_d = RX_WAIT;
                end
            end
            RX_WAIT: begin
                rx_push    = 1'b1;
                rx_clear_d = 1'b1;
                rx_state_d = RX_ACK;
                if (rx_full && !rd_en) begin
                    rx_overflow_d = 1'b1;
                end
            end
            RX_ACK: begin
                if (!rx_available) begin
                    rx_clear_d = 1'b0;
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_clear_d = 1'b0;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q    <= RX_IDLE;
            rx_clear_q    <= 1'b0;
            rx_overflow_q <= 1'b0;
        end else begin
            rx_state_q    <= rx_state_d;
            rx_clear_q    <= rx_clear_d;
            rx_overflow_q <= rx_overflow_d;
        end
    end

    assign start_tx    = start_tx_q;
    assign tx_value    = tx_value_q;
    assign rx_clear    = rx_clear_q;
    assign rx_overflow = rx_overflow_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench for uart_fifo_ctrl: stimulus queues expected TX frames and RX
// reads; monitors pop and compare when a frame starts or the CPU reads a byte.
module tb_uart_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_full;
    logic [2:0] tx_count;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rx_empty;
    logic [2:0] rx_count;
    logic       rx_overflow;
    logic       ovf_clear;
    logic       start_tx;
    logic [7:0] tx_value;
    logic       tx_done;
    logic       rx_available;
    logic [7:0] rx_value;
    logic       rx_clear;

    int         vectorCount = 0;
    int         missCount   = 0;
    logic [7:0] txExp[$];
    logic [7:0] rxExp[$];
    logic       prevStart   = 1'b0;

    uart_fifo_ctrl #(
        .TX_DEPTH     (4),
        .RX_DEPTH     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .tx_full      (tx_full),
        .tx_count     (tx_count),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rx_empty     (rx_empty),
        .rx_count     (rx_count),
        .rx_overflow  (rx_overflow),
        .ovf_clear    (ovf_clear),
        .start_tx     (start_tx),
        .tx_value     (tx_value),
        .tx_done      (tx_done),
        .rx_available (rx_available),
        .rx_value     (rx_value),
        .rx_clear     (rx_clear)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Inputs change on the falling edge; monitors look 2 time units later.
    task automatic applyStimulus(input logic wrEn, input logic [7:0] wrData, input logic expectTxAccept,
                                 input logic rdEn);
        wr_en   = wrEn;
        wr_data = wrData;
        rd_en   = rdEn;
        if (wrEn && expectTxAccept) txExp.push_back(wrData);
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic waitStartTx(input string name);
        int n = 0;
        while (start_tx !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        vectorCount++;
        if (start_tx !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL %s: start_tx still 0x%0h after %0d cycles, expected 0x1", name, start_tx, n);
        end
    endtask

    task automatic finishTxFrame();
        waitStartTx("txStartWait");
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic receiveByte(input logic [7:0] value, input logic expectAccept, input logic rdAtWait,
                               input logic clrAtWait);
        rx_available = 1'b1;
        rx_value     = 8'hEE;
        tick();
        rx_value  = value;
        rd_en     = rdAtWait;
        ovf_clear = clrAtWait;
        if (expectAccept) rxExp.push_back(value);
        tick();
        rd_en     = 1'b0;
        ovf_clear = 1'b0;
        rx_value  = 8'hEE;
        checkOutput("rxClearRise", rx_clear, 1);
        tick();
        checkOutput("rxClearHeld", rx_clear, 1);
        rx_available = 1'b0;
        tick();
        checkOutput("rxClearFall", rx_clear, 0);
    endtask

    always @(negedge clk) begin
        #2;
        if (start_tx && !prevStart) begin
            if (txExp.size() == 0) begin
                vectorCount++;
                missCount++;
                $display("[TB] FAIL txUnexpectedFrame: got frame 0x%0h, expected no frame", tx_value);
            end else begin
                checkOutput("txFrameValue", tx_value, txExp.pop_front());
            end
        end
        prevStart = start_tx;
    end

    always @(negedge clk) begin
        #2;
        if (!rst && rd_en && !rx_empty) begin
            if (rxExp.size() == 0) begin
                vectorCount++;
                missCount++;
                $display("[TB] FAIL rxUnexpectedRead: got 0x%0h, expected no data", rd_data);
            end else begin
                checkOutput("rxReadValue", rd_data, rxExp.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gap;
        rst          = 1'b1;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        rd_en        = 1'b0;
        ovf_clear    = 1'b0;
        tx_done      = 1'b0;
        rx_available = 1'b0;
        rx_value     = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        checkOutput("rstTxFull", tx_full, 0);
        checkOutput("rstTxCount", tx_count, 0);
        checkOutput("rstRxEmpty", rx_empty, 1);
        checkOutput("rstRxCount", rx_count, 0);
        checkOutput("rstOverflow", rx_overflow, 0);
        checkOutput("rstStartTx", start_tx, 0);
        checkOutput("rstTxValue", tx_value, 0);
        checkOutput("rstRxClear", rx_clear, 0);
        checkOutput("rstRdData", rd_data, 0);

        // Two queued bytes: first frame two cycles after the first write, then a 2-cycle gap.
        wr_en   = 1'b1;
        wr_data = 8'h41;
        txExp.push_back(8'h41);
        tick();
        checkOutput("txStartT0p1", start_tx, 0);
        wr_data = 8'h42;
        txExp.push_back(8'h42);
        tick();
        wr_en = 1'b0;
        checkOutput("txStartT0p2", start_tx, 1);
        checkOutput("txValueFirst", tx_value, 8'h41);
        checkOutput("txCountWrPop", tx_count, 1);
        repeat (3) tick();
        checkOutput("txHeldBusy", start_tx, 1);
        checkOutput("txValueStable", tx_value, 8'h41);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        gap = 0;
        while (!start_tx && gap < 10) begin
            gap++;
            tick();
        end
        checkOutput("txLowGap", gap, 2);
        checkOutput("txValueSecond", tx_value, 8'h42);
        finishTxFrame();
        repeat (3) tick();
        checkOutput("txDrainedCount", tx_count, 0);
        checkOutput("txDrainedStart", start_tx, 0);

        // Stalled UART: one byte in flight, four queued, the sixth write is dropped.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), i < 5, 1'b0);
        end
        checkOutput("txStallCount", tx_count, 4);
        checkOutput("txStallFull", tx_full, 1);
        checkOutput("txStallStart", start_tx, 1);
        checkOutput("txStallValue", tx_value, 8'h10);
        repeat (5) finishTxFrame();
        repeat (4) tick();
        checkOutput("txStallDrainCount", tx_count, 0);
        checkOutput("txStallDrainFull", tx_full, 0);
        checkOutput("txStallDrainStart", start_tx, 0);

        // Single received byte, then a read and a read on an empty FIFO.
        receiveByte(8'h5A, 1'b1, 1'b0, 1'b0);
        checkOutput("rxSingleData", rd_data, 8'h5A);
        checkOutput("rxSingleCount", rx_count, 1);
        checkOutput("rxSingleEmpty", rx_empty, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("rxReadEmpty", rx_empty, 1);
        checkOutput("rxReadZero", rd_data, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("rxEmptyReadCount", rx_count, 0);

        // Five bytes with no reads: the fifth overflows.
        for (int i = 0; i < 5; i++) begin
            receiveByte(8'(8'hA1 + i), i < 4, 1'b0, 1'b0);
        end
        checkOutput("rxOvfFlag", rx_overflow, 1);
        checkOutput("rxOvfCount", rx_count, 4);
        checkOutput("rxOvfHead", rd_data, 8'hA1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        checkOutput("rxOvfCleared", rx_overflow, 0);

        // Full FIFO, read and push in the same cycle: both happen, no overflow.
        receiveByte(8'hA6, 1'b1, 1'b1, 1'b0);
        checkOutput("rxFullRwCount", rx_count, 4);
        checkOutput("rxFullRwHead", rd_data, 8'hA2);
        checkOutput("rxFullRwNoOvf", rx_overflow, 0);
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("rxFullRwDrained", rx_empty, 1);

        // Overflow set and ovf_clear in the same cycle: the set wins.
        for (int i = 0; i < 4; i++) begin
            receiveByte(8'(8'hB1 + i), 1'b1, 1'b0, 1'b0);
        end
        receiveByte(8'hB5, 1'b0, 1'b0, 1'b1);
        checkOutput("rxOvfSetWins", rx_overflow, 1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        checkOutput("rxOvfClearAgain", rx_overflow, 0);
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("rxOvfDrained", rx_count, 0);

        // Reset while TX is busy and RX is acknowledging.
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h78, 1'b1, 1'b0);
        rx_available = 1'b1;
        rx_value     = 8'hEE;
        tick();
        rx_value = 8'h33;
        tick();
        checkOutput("midStartTx", start_tx, 1);
        checkOutput("midRxClear", rx_clear, 1);
        checkOutput("midTxCount", tx_count, 1);
        checkOutput("midRxCount", rx_count, 1);
        rst = 1'b1;
        txExp.delete();
        rxExp.delete();
        tick();
        checkOutput("rstMidStartTx", start_tx, 0);
        checkOutput("rstMidRxClear", rx_clear, 0);
        checkOutput("rstMidTxCount", tx_count, 0);
        checkOutput("rstMidRxCount", rx_count, 0);
        checkOutput("rstMidRxEmpty", rx_empty, 1);
        rst          = 1'b0;
        rx_available = 1'b0;
        repeat (4) tick();
        checkOutput("postRstStart", start_tx, 0);
        checkOutput("postRstTxValue", tx_value, 0);
        checkOutput("txQueueLeft", txExp.size(), 0);
        checkOutput("rxQueueLeft", rxExp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
